// File: rtl/riscv_defines.sv
// Shared definitions for the data-memory path.
// Holds the controller state encoding and the wait-state limit.
package riscv_defines;

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t ST_IDLE   = 2'd0;
    localparam dmem_state_t ST_ACCESS = 2'd1;
    localparam dmem_state_t ST_WAIT   = 2'd2;
    localparam dmem_state_t ST_RESP   = 2'd3;

    localparam int WAIT_STATES_MAX = 15;

    typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/dmem_parity.sv
// Per-byte even parity of a 32-bit word.
// Bit i is the XOR of byte i, so byte plus parity has even weight.
module dmem_parity (
    input  logic [31:0] data,
    output logic [3:0]  par
);

    assign par[0] = ^data[7:0];
    assign par[1] = ^data[15:8];
    assign par[2] = ^data[23:16];
    assign par[3] = ^data[31:24];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: LSU handshake to a single-port SRAM.
// Optional per-byte parity when DMEM_PARITY_EN is defined.
module dmem_ctrl
    import riscv_defines::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_valid_i,
    output logic        dmem_ready_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_we_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_err_o,
    output logic        sram_req_o,
    output logic [3:0]  sram_we_o,
    output logic [11:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i
`ifdef DMEM_PARITY_EN
    ,
    output logic [3:0]  sram_par_o,
    input  logic [3:0]  sram_par_i
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t   state;
    wait_cnt_t     cnt;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    we_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          rd_err;
    logic          is_read;

    logic unused_addr;
    assign unused_addr = ^{dmem_addr_i[31:AW+2], dmem_addr_i[1:0]};

    assign is_read = (we_q == 4'h0);

`ifdef DMEM_PARITY_EN
    logic [3:0] rd_par;

    dmem_parity u_par_wr (
        .data (wdata_q),
        .par  (sram_par_o)
    );

    dmem_parity u_par_rd (
        .data (sram_rdata_i),
        .par  (rd_par)
    );

    assign rd_err = |(rd_par ^ sram_par_i);
`else
    assign rd_err = 1'b0;
`endif

    // Request strobe and lanes only leave the block during ACCESS.
    assign sram_req_o   = (state == ST_ACCESS);
    assign sram_we_o    = sram_req_o ? we_q : 4'h0;
    assign sram_addr_o  = 12'(addr_q);
    assign sram_wdata_o = wdata_q;

    assign dmem_ready_o = (state == ST_RESP);
    assign dmem_rdata_o = rdata_q;

`ifdef DMEM_PARITY_EN
    assign dmem_err_o   = err_q & dmem_ready_o;
`else
    assign dmem_err_o   = 1'b0;
`endif

    // Transaction sequencer; read data and error latch on leaving WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dmem_valid_i) begin
                        addr_q  <= dmem_addr_i[AW+1:2];
                        wdata_q <= dmem_wdata_i;
                        we_q    <= dmem_we_i;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt   <= wait_cnt_t'(WAIT_STATES);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                        if (is_read) begin
                            rdata_q <= sram_rdata_i;
                            err_q   <= rd_err;
                        end else begin
                            err_q   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with behavioural SRAMs.
// Instance u_dut uses WAIT_STATES=1, u_dut0 uses WAIT_STATES=0.
module tb_dmem_ctrl;
    import riscv_defines::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        v1, rdy1, err1, sreq1;
    logic [31:0] a1, wd1, rd1, swd1, srd1;
    logic [3:0]  we1, swe1;
    logic [11:0] sad1;

    logic        v0, rdy0, err0, sreq0;
    logic [31:0] a0, wd0, rd0, swd0, srd0;
    logic [3:0]  we0, swe0;
    logic [11:0] sad0;

    logic [31:0] mem1 [0:4095];
    logic [31:0] mem0 [0:4095];

    int total = 0;
    int bad = 0;

`ifdef DMEM_PARITY_EN
    logic [3:0] spo1, spi1, spo0, spi0;
    logic [3:0] flip1 = 4'h0;
    assign spi1 = {^srd1[31:24], ^srd1[23:16],
                   ^srd1[15:8], ^srd1[7:0]} ^ flip1;
    assign spi0 = {^srd0[31:24], ^srd0[23:16],
                   ^srd0[15:8], ^srd0[7:0]};
`endif

    dmem_ctrl #(.WAIT_STATES(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_valid_i (v1),
        .dmem_ready_o (rdy1),
        .dmem_addr_i  (a1),
        .dmem_wdata_i (wd1),
        .dmem_we_i    (we1),
        .dmem_rdata_o (rd1),
        .dmem_err_o   (err1),
        .sram_req_o   (sreq1),
        .sram_we_o    (swe1),
        .sram_addr_o  (sad1),
        .sram_wdata_o (swd1),
        .sram_rdata_i (srd1)
`ifdef DMEM_PARITY_EN
        ,
        .sram_par_o   (spo1),
        .sram_par_i   (spi1)
`endif
    );

    dmem_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_valid_i (v0),
        .dmem_ready_o (rdy0),
        .dmem_addr_i  (a0),
        .dmem_wdata_i (wd0),
        .dmem_we_i    (we0),
        .dmem_rdata_o (rd0),
        .dmem_err_o   (err0),
        .sram_req_o   (sreq0),
        .sram_we_o    (swe0),
        .sram_addr_o  (sad0),
        .sram_wdata_o (swd0),
        .sram_rdata_i (srd0)
`ifdef DMEM_PARITY_EN
        ,
        .sram_par_o   (spo0),
        .sram_par_i   (spi0)
`endif
    );

    // SRAM models: read data registered one cycle after the strobe.
    always @(posedge clk) begin
        if (sreq1) begin
            if (swe1 == 4'h0) srd1 <= mem1[sad1];
            for (int b = 0; b < 4; b++)
                if (swe1[b]) mem1[sad1][b*8 +: 8] <= swd1[b*8 +: 8];
        end
        if (sreq0) begin
            if (swe0 == 4'h0) srd0 <= mem0[sad0];
            for (int b = 0; b < 4; b++)
                if (swe0[b]) mem0[sad0][b*8 +: 8] <= swd0[b*8 +: 8];
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction on u_dut; reports latency and SRAM-side view.
    task automatic xact(input  logic [31:0] a,
                        input  logic [3:0]  we,
                        input  logic [31:0] wd,
                        input  bit          drop,
                        output int          lat,
                        output int          reqs,
                        output logic [11:0] ra,
                        output logic [3:0]  rwe,
                        output logic        er,
                        output logic        rdy_after);
        bit done = 0;
        lat = 0; reqs = 0; ra = '0; rwe = '0; er = 1'b0;
        @(negedge clk);
        v1 = 1'b1; a1 = a; we1 = we; wd1 = wd;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge clk); #1;
            if (drop) v1 = 1'b0;
            if (sreq1) begin
                reqs++; ra = sad1; rwe = swe1;
            end
            if (rdy1) begin
                lat = n; er = err1; done = 1; v1 = 1'b0;
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rdy_after = rdy1;
    endtask

    int lat, reqs, hits, k;
    int t [2];
    logic [11:0] ra;
    logic [3:0] rwe;
    logic er, ra2;

    initial begin
        v1 = 0; a1 = 0; wd1 = 0; we1 = 0; srd1 = 0;
        v0 = 0; a0 = 0; wd0 = 0; we0 = 0; srd0 = 0;
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 32'h0; mem0[i] = 32'h0;
        end
        mem1[4] = 32'hDEADBEEF;
        mem1[8] = 32'h11223344;
        mem0[1] = 32'hCAFEF00D;
        mem0[2] = 32'h0BADF00D;

        #1;
        check("rst_ready", 32'(rdy1), 32'd0);
        check("rst_req", 32'(sreq1), 32'd0);
        check("rst_we", 32'(swe1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_rdata", rd1, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        xact(32'h10, 4'h0, 32'h0, 0, lat, reqs, ra, rwe, er, ra2);
        check("rd_lat", 32'(lat), 32'd4);
        check("rd_reqs", 32'(reqs), 32'd1);
        check("rd_addr", 32'(ra), 32'd4);
        check("rd_data", rd1, 32'hDEADBEEF);
        check("rd_err", 32'(er), 32'd0);
        check("rd_pulse1", 32'(ra2), 32'd0);

        xact(32'h22, 4'b0100, 32'h00AB0000, 0,
             lat, reqs, ra, rwe, er, ra2);
        check("wr_addr", 32'(ra), 32'd8);
        check("wr_we", 32'(rwe), 32'h4);
        check("wr_lat", 32'(lat), 32'd4);
        check("wr_reqs", 32'(reqs), 32'd1);
        check("wr_pulse1", 32'(ra2), 32'd0);
        check("wr_keep", rd1, 32'hDEADBEEF);
        check("wr_mem", mem1[8], 32'h11AB3344);

        xact(32'hFFFF_C020, 4'h0, 32'h0, 0,
             lat, reqs, ra, rwe, er, ra2);
        check("hi_addr", 32'(ra), 32'd8);
        check("hi_data", rd1, 32'h11AB3344);

        xact(32'h10, 4'h0, 32'h0, 1, lat, reqs, ra, rwe, er, ra2);
        check("drop_lat", 32'(lat), 32'd4);
        check("drop_data", rd1, 32'hDEADBEEF);
        check("drop_idle", 32'(u_dut.state), 32'(ST_IDLE));

        @(negedge clk);
        v0 = 1'b1; a0 = 32'h4;
        k = 0; reqs = 0; t[0] = 0; t[1] = 0;
        for (int c = 1; c <= 20 && k < 2; c++) begin
            @(posedge clk); #1;
            if (sreq0) reqs++;
            if (rdy0) begin
                t[k] = c;
                k++;
                if (k == 1) begin
                    check("b2b_d0", rd0, 32'hCAFEF00D);
                    a0 = 32'h8;
                end else begin
                    check("b2b_d1", rd0, 32'h0BADF00D);
                    v0 = 1'b0;
                end
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (sreq0) reqs++;
        end
        check("b2b_t0", 32'(t[0]), 32'd3);
        check("b2b_gap", 32'(t[1] - t[0]), 32'd4);
        check("b2b_reqs", 32'(reqs), 32'd2);

        @(negedge clk);
        v1 = 1'b1; a1 = 32'h10; we1 = 4'h0;
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        check("rw_inwait", 32'(u_dut.state), 32'(ST_WAIT));
        rst_n = 1'b0;
        #1;
        check("rw_idle", 32'(u_dut.state), 32'(ST_IDLE));
        check("rw_ready", 32'(rdy1), 32'd0);
        check("rw_req", 32'(sreq1), 32'd0);
        check("rw_rdata", rd1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy1 || sreq1) hits++;
        end
        check("rw_quiet", 32'(hits), 32'd0);
        check("rw_idle2", 32'(u_dut.state), 32'(ST_IDLE));

`ifdef DMEM_PARITY_EN
        flip1 = 4'h0;
        xact(32'h10, 4'h0, 32'h0, 0, lat, reqs, ra, rwe, er, ra2);
        check("par_ok", 32'(er), 32'd0);
        flip1 = 4'b0100;
        xact(32'h10, 4'h0, 32'h0, 0, lat, reqs, ra, rwe, er, ra2);
        check("par_bad", 32'(er), 32'd1);
        xact(32'h30, 4'hF, 32'h12345678, 0,
             lat, reqs, ra, rwe, er, ra2);
        check("par_wr", 32'(er), 32'd0);
        flip1 = 4'h0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra SRAM read/write wait cycles, legal range 0..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096: SRAM depth in 32-bit words, covering the 16 KiB data space.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 dmem_valid_i  input  1  request from the load/store unit, held until dmem_ready_o.
REQ-006 dmem_ready_o  output  1  one-cycle completion pulse.
REQ-007 dmem_addr_i  input  32  byte address; bits [13:2] form the word index.
REQ-008 dmem_wdata_i  input  32  lane-aligned write data.
REQ-009 dmem_we_i  input  4  byte write enables; 4'h0 means read.
REQ-010 dmem_rdata_o  output  32  registered read data.
REQ-011 dmem_err_o  output  1  parity error, valid with dmem_ready_o.
REQ-012 sram_req_o  output  1  SRAM access strobe.
REQ-013 sram_we_o  output  4  SRAM byte write enables.
REQ-014 sram_addr_o  output  12  SRAM word address.
REQ-015 sram_wdata_o  output  32  SRAM write data.
REQ-016 sram_rdata_i  input  32  SRAM read data, valid 1 cycle after sram_req_o.
REQ-017 sram_par_o / sram_par_i  output/input  4  per-byte parity; present only with DMEM_PARITY_EN.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, WAIT, RESP.
REQ-019 IDLE with dmem_valid_i=1 SHALL latch addr[13:2], wdata and we, then go to ACCESS.
REQ-020 ACCESS SHALL drive sram_req_o=1 for exactly one cycle with the latched fields.
REQ-021 ACCESS SHALL go to WAIT, load the wait counter with WAIT_STATES, and capture sram_rdata_i on leaving WAIT.
REQ-022 WAIT SHALL decrement the counter each cycle and exit to RESP at zero; with WAIT_STATES=0 it SHALL occupy exactly 1 cycle.
REQ-023 RESP SHALL assert dmem_ready_o for exactly one cycle and return to IDLE.
REQ-024 Latency from valid sampled to ready SHALL be 3+WAIT_STATES cycles; back-to-back requests SHALL add exactly one IDLE cycle between them.
REQ-025 Reads SHALL update dmem_rdata_o in RESP; writes SHALL leave dmem_rdata_o unchanged.
REQ-026 dmem_rdata_o SHALL hold its value until the next read response.
REQ-027 If dmem_valid_i deasserts after sampling, the transaction SHALL still complete and pulse ready.
REQ-028 Address bits [31:14] SHALL be ignored; range checking belongs upstream.
REQ-029 sram_req_o SHALL never assert outside ACCESS.

Reset
REQ-030 Reset SHALL force IDLE, counter to 0, and dmem_ready_o, sram_req_o, sram_we_o, dmem_err_o to 0, dmem_rdata_o to 32'h0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no ready pulse and no further SRAM access.

Configuration
REQ-032 With DMEM_PARITY_EN defined, writes SHALL drive sram_par_o[i] = even parity of written byte i.
REQ-033 With DMEM_PARITY_EN, reads SHALL set dmem_err_o in RESP if any byte mismatches sram_par_i; writes SHALL report dmem_err_o=0.
REQ-034 Without DMEM_PARITY_EN, the parity ports SHALL be absent and dmem_err_o SHALL be tied to 0.

Structure
REQ-035 The FSM state enum and the WAIT_STATES limit SHALL live in the shared riscv_defines package.
REQ-036 Parity generate/check SHALL be a sub-module dmem_parity (32-bit in, 4-bit parity out), instantiated twice.

Verification
REQ-037 Read addr 0x0000_0010 with WAIT_STATES=1, SRAM word 4 = 0xDEADBEEF -> sram_addr_o=4; ready 4 cycles after valid; rdata_o=0xDEADBEEF.
REQ-038 Write we=4'b0100, wdata=0x00AB0000 to 0x0000_0022 -> sram_we_o=4'b0100 at word 8; ready pulses once; rdata_o unchanged.
REQ-039 Two back-to-back reads with WAIT_STATES=0 -> ready pulses 4 cycles apart; exactly two sram_req_o pulses.
REQ-040 Reset asserted in WAIT -> no ready pulse; IDLE next cycle; sram_req_o=0.
REQ-041 DMEM_PARITY_EN, read with sram_par_i bit 2 flipped -> dmem_err_o=1 coincident with ready.
REQ-042 valid dropped the cycle after sampling -> ready still pulses and FSM returns to IDLE.
